// File: rtl/drum_audio_pkg.sv
// -----------------------------------------------------------------------------
// drum_audio_pkg
// Shared constants and helpers for the drum-mesh audio taps.
//   NODE_W / NODE_FRAC : Q2.16 node displacement format
//   AUDIO_W            : Q1.15 audio sample width
//   CONV_W             : width of the gained intermediate (node width + max gain)
//   AUDIO_MAX/MIN      : saturation limits of an audio sample
//   conv_t             : registered conversion-stage payload
//   sat_audio()        : clamp a CONV_W-bit signed value to an audio sample
// -----------------------------------------------------------------------------
package drum_audio_pkg;

  localparam int NODE_W    = 18;
  localparam int NODE_FRAC = 16;
  localparam int AUDIO_W   = 16;
  localparam int CONV_W    = NODE_W + 3;

  localparam logic [AUDIO_W-1:0] AUDIO_MAX = 16'h7FFF;
  localparam logic [AUDIO_W-1:0] AUDIO_MIN = 16'h8000;

  localparam logic signed [CONV_W-1:0] CONV_HI = CONV_W'(32'sd32767);
  localparam logic signed [CONV_W-1:0] CONV_LO = CONV_W'(-32'sd32768);

  typedef struct packed {
    logic               valid;
    logic [AUDIO_W-1:0] sample;
  } conv_t;

  function automatic logic [AUDIO_W-1:0] sat_audio(input logic signed [CONV_W-1:0] s);
    if (s > CONV_HI)      return AUDIO_MAX;
    else if (s < CONV_LO) return AUDIO_MIN;
    else                  return s[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/drum_audio_tap_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through synchronous FIFO. The head entry is presented on
// o_rdata straight from storage; a pop advances to the next entry.
//   clk, reset   : clock, synchronous active-high reset
//   i_push/i_wdata : write request and data (ignored when full unless popping)
//   i_pop        : read request (ignored when empty)
//   o_rdata      : head entry (undefined when empty)
//   o_full/o_empty/o_level : occupancy status
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which entries
  // are meaningful, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/drum_audio_tap.sv
// -----------------------------------------------------------------------------
// drum_audio_tap
// Taps one mesh node's Q2.16 displacement on every update pulse, boxcar
// averages 2^LOG2_DECIM updates, applies a 2^gain_shift gain, saturates to a
// Q1.15 audio sample and queues it in a FWFT FIFO for the codec serializer.
//   clk, reset  : clock, synchronous active-high reset
//   u_in/u_valid: node displacement and its one-cycle update strobe
//   gain_shift  : left-shift gain 0..3, used on the converting cycle
//   out_sample/out_valid/out_ready : valid/ready audio sample stream
//   overflow/clear_ovf : sticky dropped-sample flag and its clear
//   fill_level  : FIFO occupancy
// -----------------------------------------------------------------------------
module drum_audio_tap
  import drum_audio_pkg::*;
#(
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [NODE_W-1:0]      u_in,
  input  logic                          u_valid,
  input  logic [1:0]                    gain_shift,
  output logic [AUDIO_W-1:0]            out_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int ACC_W = NODE_W + LOG2_DECIM;
  // With no decimation the counter is a single bit that never leaves zero.
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);

  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  conv_t                    r_conv;
  logic                     r_overflow;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sum_shr;
  logic signed [NODE_W-1:0] w_avg;
  logic signed [CONV_W-1:0] w_gained;
  logic signed [CONV_W-1:0] w_half;
  logic                     w_last;

  logic [AUDIO_W-1:0]       w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_drop;

  // Averaging datapath: the final update joins the sum on the converting cycle.
  assign w_sum     = r_acc + ACC_W'(u_in);
  assign w_sum_shr = w_sum >>> LOG2_DECIM;
  // The mean of 2^L signed NODE_W values always fits back in NODE_W bits.
  assign w_avg     = w_sum_shr[NODE_W-1:0];
  assign w_gained  = CONV_W'(w_avg) <<< gain_shift;
  // Q2.16 -> Q1.15 drops one fractional bit and keeps the scale: >>> 1.
  assign w_half    = w_gained >>> 1;
  assign w_last    = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_conv <= '0;
    end else begin
      r_conv.valid <= 1'b0;
      if (u_valid) begin
        if (w_last) begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_conv <= '{valid: 1'b1, sample: sat_audio(w_half)};
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (AUDIO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_conv.valid),
    .i_wdata (r_conv.sample),
    .i_pop   (out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fill_level)
  );

  assign w_pop  = out_ready && !w_empty;
  assign w_drop = r_conv.valid && w_full && !w_pop;

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_ovf) r_overflow <= 1'b0;
  end

  assign overflow   = r_overflow;
  assign out_valid  = !w_empty;
  // Mask unreset storage so the sample reads 0 whenever nothing is queued.
  assign out_sample = w_empty ? '0 : w_head;

endmodule

// File: tb/tb_drum_audio_tap.sv
module tb_drum_audio_tap;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] u_in;
  logic               v0, v2;
  logic [1:0]         gain;
  logic               ready, clr;

  logic [15:0] s0, s2;
  logic        ov0, ov2, of0, of2;
  logic [3:0]  lvl0, lvl2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  drum_audio_tap #(.LOG2_DECIM(0), .FIFO_DEPTH(8)) u_dut0 (
    .clk (clk), .reset (reset), .u_in (u_in), .u_valid (v0),
    .gain_shift (gain), .out_sample (s0), .out_valid (ov0),
    .out_ready (ready), .overflow (of0), .clear_ovf (clr), .fill_level (lvl0)
  );

  drum_audio_tap #(.LOG2_DECIM(2), .FIFO_DEPTH(8)) u_dut2 (
    .clk (clk), .reset (reset), .u_in (u_in), .u_valid (v2),
    .gain_shift (gain), .out_sample (s2), .out_valid (ov2),
    .out_ready (ready), .overflow (of2), .clear_ovf (clr), .fill_level (lvl2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds the strobe for exactly one rising edge.
  task automatic pulse(input int which, input logic [17:0] val, input logic [1:0] g);
    u_in = val;
    gain = g;
    if (which == 0) v0 = 1'b1;
    else            v2 = 1'b1;
    step(1);
    v0   = 1'b0;
    v2   = 1'b0;
    gain = 2'd0;
  endtask

  task automatic pop();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  // One undecimated sample through dut0, checked and then drained.
  task automatic one(input string tag, input logic [17:0] val, input logic [1:0] g,
                     input logic [15:0] exp);
    pulse(0, val, g);
    step(1);
    chk(tag, s0, exp);
    pop();
  endtask

  initial begin
    reset = 1'b1; u_in = '0; v0 = 1'b0; v2 = 1'b0;
    gain = 2'd0; ready = 1'b0; clr = 1'b0;
    step(3);
    reset = 1'b0;

    chk("rst_valid0", ov0, 0);
    chk("rst_sample0", s0, 0);
    chk("rst_level0", lvl0, 0);
    chk("rst_ovf0", of0, 0);
    chk("rst_valid2", ov2, 0);

    // No decimation: +0.5 -> 0x4000, visible two edges after the pulse edge.
    pulse(0, 18'h08000, 2'd0);
    chk("lat_e0_valid", ov0, 0);
    step(1);
    chk("lat_e1_valid", ov0, 1);
    chk("half_sample", s0, 16'h4000);
    chk("half_level", lvl0, 1);
    pop();
    chk("pop_empty", ov0, 0);

    // Saturation and gain.
    one("sat_pos",   18'h10000, 2'd0, 16'h7FFF);
    one("neg_one",   18'h30000, 2'd0, 16'h8000);
    one("gain3_sat", 18'h04000, 2'd3, 16'h7FFF);
    one("gain1_neg", 18'h3C000, 2'd1, 16'hC000);

    // Decimate by 4: mean 0x6000 -> 0x3000, nothing after three pulses.
    pulse(2, 18'h04000, 2'd0);
    pulse(2, 18'h08000, 2'd0);
    pulse(2, 18'h0C000, 2'd0);
    step(2);
    chk("decim_partial", ov2, 0);
    pulse(2, 18'h00000, 2'd0);
    step(1);
    chk("decim_valid", ov2, 1);
    chk("decim_sample", s2, 16'h3000);
    pop();

    // Overflow: nine samples k*0x200 into an 8-deep FIFO with no consumer.
    for (int k = 1; k <= 9; k++) pulse(0, 18'(k * 32'h400), 2'd0);
    step(1);
    chk("ovf_level", lvl0, 8);
    chk("ovf_flag", of0, 1);
    step(2);
    chk("ovf_sticky", of0, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_cleared", of0, 0);
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_order", s0, 16'(k * 32'h200));
      pop();
    end
    chk("ovf_drained", ov0, 0);

    // Refill, then push and pop on the same edge while full.
    for (int k = 1; k <= 8; k++) pulse(0, 18'(k * 32'h400), 2'd0);
    step(1);
    chk("refill_level", lvl0, 8);
    pulse(0, 18'h02400, 2'd0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("pushpop_level", lvl0, 8);
    chk("pushpop_noovf", of0, 0);
    for (int k = 2; k <= 8; k++) begin
      chk("pushpop_order", s0, 16'(k * 32'h200));
      pop();
    end
    chk("pushpop_last", s0, 16'h1200);
    pop();
    chk("pushpop_empty", ov0, 0);

    // Reset mid-average discards both the queued sample and the partial sum.
    for (int k = 0; k < 4; k++) pulse(2, 18'h04000, 2'd0);
    pulse(2, 18'h3C000, 2'd0);
    pulse(2, 18'h3C000, 2'd0);
    chk("pre_rst_level", lvl2, 1);
    reset = 1'b1;
    step(1);
    chk("in_rst_level", lvl2, 0);
    chk("in_rst_valid", ov2, 0);
    chk("in_rst_sample", s2, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) pulse(2, 18'h08000, 2'd0);
    step(1);
    chk("post_rst_level", lvl2, 1);
    chk("post_rst_sample", s2, 16'h4000);
    pop();
    chk("post_rst_empty", ov2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
